// File: rtl/sorter_pkg.sv
// Shared types for the bitonic merge sorter.
// Tuples carry an ordered (lo, hi) element pair.
package sorter_pkg;

    localparam int ELEM_W = 128;

    typedef struct packed {
        logic [ELEM_W-1:0] hi;
        logic [ELEM_W-1:0] lo;
    } tuple_t;

    typedef enum logic [1:0] {
        LOAD,
        ISSUE,
        WAIT,
        FLUSH
    } merge_state_t;

    function automatic logic tuple_lt(
        input tuple_t a,
        input tuple_t b
    );
        return a.lo < b.lo;
    endfunction

endpackage

// File: rtl/merge_head_select.sv
// Chooses which stream head feeds the merge next.
// Ties go to stream A so equal keys keep stream order.
module merge_head_select
    import sorter_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic [2*DATA_WIDTH-1:0] a_head,
    input  logic [2*DATA_WIDTH-1:0] b_head,
    input  logic                    a_valid,
    input  logic                    b_valid,
    input  logic                    a_done,
    input  logic                    b_done,
    output logic                    pick_valid,
    output logic                    pick_b
);

    tuple_t a_t;
    tuple_t b_t;

    always_comb begin
        a_t = '0;
        b_t = '0;
        a_t.lo[DATA_WIDTH-1:0] = a_head[DATA_WIDTH-1:0];
        a_t.hi[DATA_WIDTH-1:0] = a_head[2*DATA_WIDTH-1:DATA_WIDTH];
        b_t.lo[DATA_WIDTH-1:0] = b_head[DATA_WIDTH-1:0];
        b_t.hi[DATA_WIDTH-1:0] = b_head[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Two live streams must both present a head before comparing
    always_comb begin
        pick_valid = 1'b0;
        pick_b     = 1'b0;
        unique case ({a_done, b_done})
            2'b00: begin
                pick_valid = a_valid & b_valid;
                pick_b     = tuple_lt(b_t, a_t);
            end
            2'b10: begin
                pick_valid = b_valid;
                pick_b     = 1'b1;
            end
            2'b01: begin
                pick_valid = a_valid;
            end
            default: begin
                pick_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/merge_2_ctrl.sv
// Sequencer feeding a 2-wide bitonic merge network from two
// sorted tuple streams; one tuple in flight at a time.
module merge_2_ctrl
    import sorter_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [2*DATA_WIDTH-1:0] i_a_data,
    input  logic                    i_a_valid,
    input  logic                    i_a_last,
    output logic                    o_a_ready,
    input  logic [2*DATA_WIDTH-1:0] i_b_data,
    input  logic                    i_b_valid,
    input  logic                    i_b_last,
    output logic                    o_b_ready,
    output logic [2*DATA_WIDTH-1:0] o_net_elems_0,
    output logic [2*DATA_WIDTH-1:0] o_net_elems_1,
    output logic                    o_net_stall,
    output logic                    o_net_switch_output,
    input  logic [2*DATA_WIDTH-1:0] i_net_elems_0,
    input  logic [2*DATA_WIDTH-1:0] i_net_elems_1,
    input  logic                    i_net_stall,
    input  logic                    i_net_switch_output,
    output logic [2*DATA_WIDTH-1:0] o_data,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_done
);

    localparam int TW = 2 * DATA_WIDTH;

    merge_state_t  state;
    logic [TW-1:0] fb;
    logic [TW-1:0] pick;
    logic          a_done;
    logic          b_done;
    logic          pick_valid;
    logic          pick_b;
    logic          pick_last;
    logic          other_done;
    logic          out_free;
    logic          pending;

    merge_head_select #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sel (
        .a_head    (i_a_data),
        .b_head    (i_b_data),
        .a_valid   (i_a_valid),
        .b_valid   (i_b_valid),
        .a_done    (a_done),
        .b_done    (b_done),
        .pick_valid(pick_valid),
        .pick_b    (pick_b)
    );

    assign pick       = pick_b ? i_b_data : i_a_data;
    assign pick_last  = pick_b ? i_b_last : i_a_last;
    assign other_done = pick_b ? a_done : b_done;
    assign out_free   = !o_valid || i_ready;
    // Pop strobes are registered, so the head is stale while one is out
    assign pending    = o_a_ready | o_b_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state               <= LOAD;
            fb                  <= '0;
            a_done              <= 1'b0;
            b_done              <= 1'b0;
            o_a_ready           <= 1'b0;
            o_b_ready           <= 1'b0;
            o_net_elems_0       <= '0;
            o_net_elems_1       <= '0;
            o_net_stall         <= 1'b1;
            o_net_switch_output <= 1'b0;
            o_data              <= '0;
            o_valid             <= 1'b0;
            o_done              <= 1'b0;
        end else begin
            o_a_ready           <= 1'b0;
            o_b_ready           <= 1'b0;
            o_net_stall         <= 1'b1;
            o_net_switch_output <= 1'b0;
            o_done              <= 1'b0;
            if (o_valid && i_ready)
                o_valid <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (pick_valid && !pending) begin
                        fb        <= pick;
                        o_a_ready <= !pick_b;
                        o_b_ready <= pick_b;
                        if (pick_last) begin
                            a_done <= a_done | !pick_b;
                            b_done <= b_done | pick_b;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (a_done && b_done) begin
                        state <= FLUSH;
                    end else if (pick_valid && !pending && out_free) begin
                        o_net_elems_0       <= pick;
                        o_net_elems_1       <= fb;
                        o_net_stall         <= 1'b0;
                        o_net_switch_output <= pick_last && other_done;
                        o_a_ready           <= !pick_b;
                        o_b_ready           <= pick_b;
                        if (pick_last) begin
                            a_done <= a_done | !pick_b;
                            b_done <= b_done | pick_b;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!i_net_stall) begin
                        o_data  <= i_net_elems_0;
                        o_valid <= 1'b1;
                        fb      <= i_net_elems_1;
                        if ((a_done && b_done) || i_net_switch_output)
                            state <= FLUSH;
                        else
                            state <= ISSUE;
                    end
                end
                FLUSH: begin
                    if (out_free) begin
                        o_data  <= fb;
                        o_valid <= 1'b1;
                        o_done  <= 1'b1;
                        a_done  <= 1'b0;
                        b_done  <= 1'b0;
                        state   <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_merge_2_ctrl.sv
// Directed bench for merge_2_ctrl with a behavioural merge
// network, upstream queues and a scoreboard monitor.
module tb_merge_2_ctrl;

    localparam int DW = 8;
    localparam int TW = 16;

    typedef struct packed {
        logic          last;
        logic [TW-1:0] data;
    } item_t;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic [TW-1:0] i_a_data = '0;
    logic          i_a_valid = 1'b0;
    logic          i_a_last = 1'b0;
    logic          o_a_ready;
    logic [TW-1:0] i_b_data = '0;
    logic          i_b_valid = 1'b0;
    logic          i_b_last = 1'b0;
    logic          o_b_ready;
    logic [TW-1:0] o_net_elems_0;
    logic [TW-1:0] o_net_elems_1;
    logic          o_net_stall;
    logic          o_net_switch_output;
    logic [TW-1:0] i_net_elems_0;
    logic [TW-1:0] i_net_elems_1;
    logic          i_net_stall;
    logic          i_net_switch_output;
    logic [TW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b1;
    logic          o_done;

    item_t qa[$];
    item_t qb[$];
    item_t exp_q[$];
    logic  pop_log[$];
    int    checks = 0;
    int    errors = 0;
    int    done_cnt = 0;
    logic  pa = 1'b0;
    logic  pb = 1'b0;

    always #5 i_clk = ~i_clk;

    merge_2_ctrl #(.DATA_WIDTH(DW)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_a_data           (i_a_data),
        .i_a_valid          (i_a_valid),
        .i_a_last           (i_a_last),
        .o_a_ready          (o_a_ready),
        .i_b_data           (i_b_data),
        .i_b_valid          (i_b_valid),
        .i_b_last           (i_b_last),
        .o_b_ready          (o_b_ready),
        .o_net_elems_0      (o_net_elems_0),
        .o_net_elems_1      (o_net_elems_1),
        .o_net_stall        (o_net_stall),
        .o_net_switch_output(o_net_switch_output),
        .i_net_elems_0      (i_net_elems_0),
        .i_net_elems_1      (i_net_elems_1),
        .i_net_stall        (i_net_stall),
        .i_net_switch_output(i_net_switch_output),
        .o_data             (o_data),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_done             (o_done)
    );

    function automatic logic [TW-1:0] tup(input int lo, input int hi);
        return {hi[DW-1:0], lo[DW-1:0]};
    endfunction

    function automatic item_t mk(input int lo, input int hi, input logic l);
        item_t it;
        it.last = l;
        it.data = tup(lo, hi);
        return it;
    endfunction

    // Full 4-element sort; lower pair first, upper pair second
    function automatic logic [2*TW-1:0] merge4(
        input logic [TW-1:0] x,
        input logic [TW-1:0] y
    );
        logic [DW-1:0] e[4];
        logic [DW-1:0] t;
        e[0] = x[DW-1:0];
        e[1] = x[TW-1:DW];
        e[2] = y[DW-1:0];
        e[3] = y[TW-1:DW];
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (e[j] > e[j+1]) begin
                    t = e[j];
                    e[j] = e[j+1];
                    e[j+1] = t;
                end
        return {e[3], e[2], e[1], e[0]};
    endfunction

    logic          s1_v = 1'b0;
    logic          s2_v = 1'b0;
    logic          s1_t = 1'b0;
    logic          s2_t = 1'b0;
    logic [TW-1:0] s1_lo = '0;
    logic [TW-1:0] s1_hi = '0;
    logic [TW-1:0] s2_lo = '0;
    logic [TW-1:0] s2_hi = '0;

    always @(posedge i_clk) begin
        s1_v <= !o_net_stall;
        s1_t <= o_net_switch_output;
        {s1_hi, s1_lo} <= merge4(o_net_elems_0, o_net_elems_1);
        s2_v  <= s1_v;
        s2_t  <= s1_t;
        s2_lo <= s1_lo;
        s2_hi <= s1_hi;
    end

    assign i_net_stall         = !s2_v;
    assign i_net_switch_output = s2_t;
    assign i_net_elems_0       = s2_lo;
    assign i_net_elems_1       = s2_hi;

    always @(negedge i_clk) begin
        pa = o_a_ready && i_a_valid;
        pb = o_b_ready && i_b_valid;
    end

    always @(posedge i_clk) begin
        item_t tmp;
        #1;
        if (pa && qa.size() != 0) begin
            tmp = qa.pop_front();
            pop_log.push_back(1'b0);
        end
        if (pb && qb.size() != 0) begin
            tmp = qb.pop_front();
            pop_log.push_back(1'b1);
        end
        i_a_valid = qa.size() != 0;
        i_a_data  = i_a_valid ? qa[0].data : '0;
        i_a_last  = i_a_valid ? qa[0].last : 1'b0;
        i_b_valid = qb.size() != 0;
        i_b_data  = i_b_valid ? qb[0].data : '0;
        i_b_last  = i_b_valid ? qb[0].last : 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    logic          prev_held = 1'b0;
    logic [TW-1:0] prev_data = '0;

    always @(negedge i_clk) begin
        item_t e;
        if (!i_rst_n) begin
            prev_held = 1'b0;
        end else begin
            if (o_done)
                done_cnt++;
            if (o_valid) begin
                if (prev_held) begin
                    chk("hold_data", 32'(o_data), 32'(prev_data));
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(o_valid), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", 32'(o_data), 32'(e.data));
                    chk("out_done", 32'(o_done), 32'(e.last));
                end
            end
            prev_held = o_valid && !i_ready;
            prev_data = o_data;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic start_case();
        exp_q.delete();
        pop_log.delete();
        done_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || o_valid) && n < 400) begin
            tick();
            n++;
        end
        chk({name, "_timeout"}, 32'(n >= 400), 32'(0));
        repeat (3) tick();
    endtask

    task automatic chk_pops(input string name, input int n,
                            input logic [7:0] pat);
        logic [7:0] got = '0;
        foreach (pop_log[i]) got = {got[6:0], pop_log[i]};
        chk({name, "_npop"}, 32'(pop_log.size()), 32'(n));
        chk({name, "_order"}, 32'(got), 32'(pat));
        chk({name, "_ndone"}, 32'(done_cnt), 32'(1));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_valid"}, 32'(o_valid), 32'(0));
        chk({name, "_data"}, 32'(o_data), 32'(0));
        chk({name, "_done"}, 32'(o_done), 32'(0));
        chk({name, "_ready"}, 32'({o_a_ready, o_b_ready}), 32'(0));
        chk({name, "_stall"}, 32'(o_net_stall), 32'(1));
        chk({name, "_tag"}, 32'(o_net_switch_output), 32'(0));
        chk({name, "_elems"}, 32'({o_net_elems_0, o_net_elems_1}), 32'(0));
    endtask

    task automatic load_basic();
        qa.push_back(mk(1, 3, 1'b0));
        qa.push_back(mk(5, 7, 1'b1));
        qb.push_back(mk(2, 4, 1'b0));
        qb.push_back(mk(6, 8, 1'b1));
        exp_q.push_back(mk(1, 2, 1'b0));
        exp_q.push_back(mk(3, 4, 1'b0));
        exp_q.push_back(mk(5, 6, 1'b0));
        exp_q.push_back(mk(7, 8, 1'b1));
    endtask

    initial begin
        int n;
        repeat (2) tick();
        chk_reset("reset");
        i_rst_n = 1'b1;
        repeat (2) tick();

        start_case();
        load_basic();
        wait_idle("basic");
        chk_pops("basic", 4, 8'b0101);

        start_case();
        load_basic();
        n = 0;
        while (!o_valid && n < 100) begin
            tick();
            n++;
        end
        chk("bp_first_timeout", 32'(n >= 100), 32'(0));
        i_ready = 1'b0;
        repeat (10) begin
            tick();
            chk("bp_stall", 32'(o_net_stall), 32'(1));
            chk("bp_pop", 32'({o_a_ready, o_b_ready}), 32'(0));
            chk("bp_data", 32'(o_data), 32'(tup(1, 2)));
        end
        i_ready = 1'b1;
        wait_idle("bp");
        chk_pops("bp", 4, 8'b0101);

        start_case();
        qa.push_back(mk(4, 9, 1'b1));
        qb.push_back(mk(4, 5, 1'b1));
        exp_q.push_back(mk(4, 4, 1'b0));
        exp_q.push_back(mk(5, 9, 1'b1));
        wait_idle("tie");
        chk_pops("tie", 2, 8'b01);

        start_case();
        qa.push_back(mk(0, 1, 1'b1));
        qb.push_back(mk(2, 3, 1'b0));
        qb.push_back(mk(4, 5, 1'b0));
        qb.push_back(mk(6, 7, 1'b1));
        exp_q.push_back(mk(0, 1, 1'b0));
        exp_q.push_back(mk(2, 3, 1'b0));
        exp_q.push_back(mk(4, 5, 1'b0));
        exp_q.push_back(mk(6, 7, 1'b1));
        wait_idle("early");
        chk_pops("early", 4, 8'b0111);

        start_case();
        qa.push_back(mk(9, 9, 1'b1));
        qb.push_back(mk(9, 9, 1'b1));
        exp_q.push_back(mk(9, 9, 1'b0));
        exp_q.push_back(mk(9, 9, 1'b1));
        wait_idle("dup");
        chk_pops("dup", 2, 8'b01);

        start_case();
        load_basic();
        n = 0;
        while (o_net_stall && n < 100) begin
            tick();
            n++;
        end
        chk("rst_issue_timeout", 32'(n >= 100), 32'(0));
        tick();
        i_rst_n = 1'b0;
        qa.delete();
        qb.delete();
        tick();
        chk_reset("midrst");
        start_case();
        i_rst_n = 1'b1;
        load_basic();
        wait_idle("after_rst");
        chk_pops("after_rst", 4, 8'b0101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
